// File: rtl/arith_pkg.sv
// Shared arithmetic constants and elaboration-time helpers for the
// carry-lookahead adder family.
package arith_pkg;

   localparam int CLA_GROUP = 4;

   // Legal widths are whole numbers of lookahead groups.
   function automatic bit check_width(input int width);
      return (width >= CLA_GROUP) && ((width % CLA_GROUP) == 0);
   endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: flat lookahead for the internal carries,
// plus group propagate/generate for the next lookahead level.
module cla_group4
   import arith_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout,
   output logic       p_grp,
   output logic       g_grp
);

   logic [3:0] w_p;
   logic [3:0] w_g;
   logic [3:0] w_c;

   assign w_p = a ^ b;
   assign w_g = a & b;

   // Each carry is a two-level sum of products, so no ripple inside the group.
   assign w_c[0] = cin;
   assign w_c[1] = w_g[0] | (w_p[0] & cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & cin);

   assign p_grp = &w_p;
   assign g_grp = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

   assign cout = g_grp | (p_grp & cin);
   assign s    = w_p ^ w_c;

endmodule

// File: rtl/adder_4bit.sv
// Unsigned adder {carry, sum} = dataA + dataB built from 4-bit lookahead
// groups, with an optional output register stage and a valid flag.
module adder_4bit
   import arith_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int OUT_REG = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             out_valid
);

   localparam int N_GRP = WIDTH / CLA_GROUP;

   generate
      if (!check_width(WIDTH)) begin : g_bad_width
         $error("adder_4bit: WIDTH must be a positive multiple of 4");
      end
   endgenerate

   logic [WIDTH-1:0] w_sum;
   logic [N_GRP:0]   w_carry;
   logic [N_GRP-1:0] w_gp;
   logic [N_GRP-1:0] w_gg;
   logic [N_GRP-1:0] w_cout;
   logic             w_unused;

   assign w_carry[0] = 1'b0;

   // Inter-group carries come from group P/G, so the per-group cout is
   // redundant here; it only feeds the unused sink below.
   genvar gi;
   generate
      for (gi = 0; gi < N_GRP; gi++) begin : g_grp
         cla_group4 u_grp (
            .a     (dataA[gi*CLA_GROUP +: CLA_GROUP]),
            .b     (dataB[gi*CLA_GROUP +: CLA_GROUP]),
            .cin   (w_carry[gi]),
            .s     (w_sum[gi*CLA_GROUP +: CLA_GROUP]),
            .cout  (w_cout[gi]),
            .p_grp (w_gp[gi]),
            .g_grp (w_gg[gi])
         );
         assign w_carry[gi+1] = w_gg[gi] | (w_gp[gi] & w_carry[gi]);
      end
   endgenerate

   assign w_unused = ^{w_cout, clk, rst};

   generate
      if (OUT_REG != 0) begin : g_reg
         logic [WIDTH-1:0] r_sum;
         logic             r_carry;
         logic             r_valid;

         // Reset wins over in_valid; results only update on a valid pair.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_sum   <= '0;
               r_carry <= 1'b0;
               r_valid <= 1'b0;
            end else begin
               r_valid <= in_valid;
               if (in_valid) begin
                  r_sum   <= w_sum;
                  r_carry <= w_carry[N_GRP];
               end
            end
         end

         assign sum       = r_sum;
         assign carry     = r_carry;
         assign out_valid = r_valid;
      end else begin : g_comb
         assign sum       = w_sum;
         assign carry     = w_carry[N_GRP];
         assign out_valid = in_valid;
      end
   endgenerate

endmodule

// File: tb/tb_adder_4bit.sv
// Bench for adder_4bit: directed literal vectors plus exhaustive/random
// traffic compared each cycle against a plain-arithmetic model.
module tb_adder_4bit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [3:0]  a4, b4, ac, bc;
   logic [15:0] a16, b16;

   logic [3:0]  u4_sum, uc_sum;
   logic [15:0] u16_sum;
   logic        u4_carry, u4_valid, u16_carry, u16_valid, uc_carry, uc_valid;

   int checks = 0;
   int errors = 0;

   // Reference model state (registered configurations)
   logic [3:0]  m4_sum;
   logic        m4_carry, m4_valid;
   logic [15:0] m16_sum;
   logic        m16_carry, m16_valid;
   logic        model_live = 1'b0;

   always #5 clk = ~clk;

   adder_4bit #(.WIDTH(4), .OUT_REG(1)) u_dut4 (
      .clk(clk), .rst(rst), .dataA(a4), .dataB(b4), .in_valid(in_valid),
      .sum(u4_sum), .carry(u4_carry), .out_valid(u4_valid));

   adder_4bit #(.WIDTH(16), .OUT_REG(1)) u_dut16 (
      .clk(clk), .rst(rst), .dataA(a16), .dataB(b16), .in_valid(in_valid),
      .sum(u16_sum), .carry(u16_carry), .out_valid(u16_valid));

   adder_4bit #(.WIDTH(4), .OUT_REG(0)) u_dutc (
      .clk(clk), .rst(rst), .dataA(ac), .dataB(bc), .in_valid(in_valid),
      .sum(uc_sum), .carry(uc_carry), .out_valid(uc_valid));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: true sum at WIDTH+1 bits, captured only on valid, cleared by reset.
   always @(posedge clk) begin
      if (rst) begin
         m4_sum <= '0;  m4_carry <= 1'b0;  m4_valid <= 1'b0;
         m16_sum <= '0; m16_carry <= 1'b0; m16_valid <= 1'b0;
         model_live <= 1'b1;
      end else begin
         m4_valid  <= in_valid;
         m16_valid <= in_valid;
         if (in_valid) begin
            {m4_carry, m4_sum}   <= 5'(a4) + 5'(b4);
            {m16_carry, m16_sum} <= 17'(a16) + 17'(b16);
         end
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         chk("cmp_w4", 32'({u4_carry, u4_sum, u4_valid}), 32'({m4_carry, m4_sum, m4_valid}));
         chk("cmp_w16", 32'({u16_carry, u16_sum, u16_valid}),
             32'({m16_carry, m16_sum, m16_valid}));
         chk("cmp_comb", 32'({uc_carry, uc_sum, uc_valid}),
             32'({5'(ac) + 5'(bc), in_valid}));
      end
   end

   // Drive one cycle of inputs, then land 1 time unit after the capturing edge.
   task automatic step(input logic [3:0] a, input logic [3:0] b, input logic v,
                       input logic r, input logic [15:0] x, input logic [15:0] y);
      a4 = a; b4 = b; in_valid = v; rst = r; a16 = x; b16 = y;
      ac = 4'($urandom); bc = 4'($urandom);
      @(posedge clk);
      #1;
   endtask

   task automatic lit4(input string name, input logic [3:0] s, input logic c, input logic v);
      chk(name, 32'({u4_carry, u4_sum, u4_valid}), 32'({c, s, v}));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0;
      a4 = '0; b4 = '0; ac = '0; bc = '0; a16 = '0; b16 = '0;
      repeat (2) @(posedge clk);
      #1;
      lit4("reset_w4", 4'h0, 1'b0, 1'b0);
      chk("reset_w16", 32'({u16_carry, u16_sum, u16_valid}), 32'h0);

      step(4'h0, 4'h0, 1'b1, 1'b0, 16'h0, 16'h0);  lit4("0+0", 4'h0, 1'b0, 1'b1);
      step(4'h0, 4'h1, 1'b1, 1'b0, 16'h0, 16'h0);  lit4("0+1", 4'h1, 1'b0, 1'b1);
      step(4'h1, 4'h1, 1'b1, 1'b0, 16'h0, 16'h0);  lit4("1+1", 4'h2, 1'b0, 1'b1);
      step(4'h3, 4'h2, 1'b1, 1'b0, 16'h0, 16'h0);  lit4("3+2", 4'h5, 1'b0, 1'b1);
      step(4'h9, 4'h9, 1'b0, 1'b0, 16'h0, 16'h0);  lit4("hold", 4'h5, 1'b0, 1'b0);
      step(4'hF, 4'h1, 1'b1, 1'b1, 16'h0, 16'h0);  lit4("rst_mid", 4'h0, 1'b0, 1'b0);
      step(4'h1, 4'h1, 1'b1, 1'b0, 16'h0, 16'h0);  lit4("post_rst", 4'h2, 1'b0, 1'b1);
      step(4'hF, 4'h1, 1'b1, 1'b0, 16'hFFFF, 16'h0001);
      lit4("F+1", 4'h0, 1'b1, 1'b1);
      chk("FFFF+0001", 32'({u16_carry, u16_sum, u16_valid}), 32'({1'b1, 16'h0000, 1'b1}));
      step(4'hF, 4'hF, 1'b1, 1'b0, 16'h8000, 16'h7FFF);
      lit4("F+F", 4'hE, 1'b1, 1'b1);
      chk("8000+7FFF", 32'({u16_carry, u16_sum, u16_valid}), 32'({1'b0, 16'hFFFF, 1'b1}));

      // Combinational configuration responds within the same cycle.
      ac = 4'h7; bc = 4'h9; in_valid = 1'b1;
      #1;
      chk("comb_7+9", 32'({uc_carry, uc_sum, uc_valid}), 32'({1'b1, 4'h0, 1'b1}));
      @(posedge clk);
      #1;

      // Exhaustive 4-bit pairs, back to back.
      for (int k = 0; k < 256; k++) begin
         logic [7:0] kk;
         kk = 8'(k);
         step(kk[7:4], kk[3:0], 1'b1, 1'b0, 16'($urandom), 16'($urandom));
      end

      // Random traffic with gaps, occasional resets, and corner operands.
      for (int k = 0; k < 400; k++) begin
         logic [15:0] x, y;
         x = 16'($urandom);
         y = 16'($urandom);
         if ($urandom_range(0, 7) == 0) x = 16'hFFFF;
         if ($urandom_range(0, 7) == 0) y = 16'h0001;
         step(4'($urandom), 4'($urandom), ($urandom_range(0, 4) != 0),
              ($urandom_range(0, 39) == 0), x, y);
      end

      step(4'h0, 4'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
